// File: rtl/dwt_pkg.sv
// Shared types and arithmetic helpers for the 2-D Haar DWT stream engine.
// Optional rounding is selected with the DWT_ROUND_EN macro.
package dwt_pkg;

   localparam int PIX_W  = 8;
   localparam int COEF_W = PIX_W + 1;
   localparam int LB_W   = 2 * COEF_W;
   localparam int ACC_W  = PIX_W + 3;

   typedef logic signed [ACC_W-1:0] acc_t;

   // One line-buffer word: horizontal sum and difference of a top-row pair
   typedef struct packed {
      logic        [COEF_W-1:0] s;
      logic signed [COEF_W-1:0] t;
   } lb_entry_t;

   // $clog2 that never yields a zero-width vector
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Approximation scaling: divide the four-pixel sum by 4
   function automatic acc_t ll_shift(input acc_t x);
`ifdef DWT_ROUND_EN
      return (x + acc_t'(2)) >>> 2;
`else
      return x >>> 2;
`endif
   endfunction

   // Detail scaling: halve a signed combination of sums/differences
   function automatic acc_t det_shift(input acc_t x);
`ifdef DWT_ROUND_EN
      return (x + acc_t'(1)) >>> 1;
`else
      return x >>> 1;
`endif
   endfunction

endpackage

// File: rtl/dwt_line_buf.sv
// Half-width line buffer: holds {sum, diff} of each even-row pixel pair until
// the matching odd-row pair arrives. Registered read, held when rd_en is low.
module dwt_line_buf
   import dwt_pkg::*;
#(
   parameter int DEPTH = 384,
   parameter int AW    = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  lb_entry_t     wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output lb_entry_t     rd_data
);

   lb_entry_t mem_q [DEPTH];
   lb_entry_t rd_data_q, rd_data_d;

   // Read data only changes when a read is issued
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Read data register
   always_ff @(posedge clk) begin
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/haar_dwt2d_stream.sv
// Single-level 2-D Haar DWT on a raster pixel stream; one LL/LH/HL/HH group
// per 2x2 block. Rounding mode selected by the DWT_ROUND_EN macro.
// WIDTH and HEIGHT must be even and WIDTH >= 4.
module haar_dwt2d_stream
   import dwt_pkg::COEF_W, dwt_pkg::acc_t, dwt_pkg::lb_entry_t,
          dwt_pkg::ll_shift, dwt_pkg::det_shift, dwt_pkg::clog2_min1;
#(
   parameter int  WIDTH  = 768,
   parameter int  HEIGHT = 512,
   parameter int  PIX_W  = dwt_pkg::PIX_W,
   localparam int ORW    = clog2_min1(HEIGHT / 2),
   localparam int OCW    = clog2_min1(WIDTH / 2)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_ll,
   output logic [PIX_W:0]   out_lh,
   output logic [PIX_W:0]   out_hl,
   output logic [PIX_W:0]   out_hh,
   output logic [ORW-1:0]   out_row,
   output logic [OCW-1:0]   out_col,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [PIX_W-1:0] pix_q, pix_d;       // pixel a (even row) or c (odd row)
   logic             out_valid_q, out_valid_d;
   logic             last_q, last_d;     // held group closes the frame
   logic             frame_done_q, frame_done_d;
   logic [PIX_W-1:0] ll_q, ll_d;
   logic [PIX_W:0]   lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
   logic [ORW-1:0]   orow_q, orow_d;
   logic [OCW-1:0]   ocol_q, ocol_d;

   logic      accept, load, lb_wr, lb_rd;
   logic      last_col, last_row;
   logic [OCW-1:0] lb_addr;
   lb_entry_t lb_wdata, lb_rdata;
   acc_t      s, t, s2, t2;

   assign in_ready = ~(out_valid_q & ~out_ready);
   assign accept   = in_valid & in_ready;
   assign lb_wr    = accept & ~row_q[0] &  col_q[0];
   assign lb_rd    = accept &  row_q[0] & ~col_q[0];
   assign load     = accept &  row_q[0] &  col_q[0];
   assign lb_addr  = OCW'(col_q >> 1);
   assign last_col = (col_q == CW'(WIDTH - 1));
   assign last_row = (row_q == RW'(HEIGHT - 1));

   dwt_line_buf #(.DEPTH(WIDTH / 2), .AW(OCW)) u_lb (
      .clk     (HCLK),
      .wr_en   (lb_wr),
      .wr_addr (lb_addr),
      .wr_data (lb_wdata),
      .rd_en   (lb_rd),
      .rd_addr (lb_addr),
      .rd_data (lb_rdata)
   );

   // Horizontal butterflies: top pair goes to the buffer, bottom pair is live
   always_comb begin
      lb_wdata.s = COEF_W'(pix_q) + COEF_W'(in_pixel);
      lb_wdata.t = COEF_W'(pix_q) - COEF_W'(in_pixel);
      s  = acc_t'(lb_rdata.s);
      t  = acc_t'(lb_rdata.t);
      s2 = acc_t'(pix_q) + acc_t'(in_pixel);
      t2 = acc_t'(pix_q) - acc_t'(in_pixel);
   end

   // Raster counters, pair latch and output register next-state
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pix_d        = pix_q;
      out_valid_d  = out_valid_q;
      last_d       = last_q;
      ll_d         = ll_q;
      lh_d         = lh_q;
      hl_d         = hl_q;
      hh_d         = hh_q;
      orow_d       = orow_q;
      ocol_d       = ocol_q;
      frame_done_d = out_valid_q & out_ready & last_q;

      if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (!col_q[0]) pix_d = in_pixel;
      end

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      // A new group may land in the same cycle the old one drains
      if (load) begin
         out_valid_d = 1'b1;
         last_d      = last_col & last_row;
         ll_d        = PIX_W'(ll_shift(s + s2));
         lh_d        = (PIX_W+1)'(det_shift(s - s2));
         hl_d        = (PIX_W+1)'(det_shift(t + t2));
         hh_d        = (PIX_W+1)'(det_shift(t - t2));
         orow_d      = ORW'(row_q >> 1);
         ocol_d      = OCW'(col_q >> 1);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         col_q        <= '0;
         row_q        <= '0;
         pix_q        <= '0;
         out_valid_q  <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         ll_q         <= '0;
         lh_q         <= '0;
         hl_q         <= '0;
         hh_q         <= '0;
         orow_q       <= '0;
         ocol_q       <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pix_q        <= pix_d;
         out_valid_q  <= out_valid_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
         ll_q         <= ll_d;
         lh_q         <= lh_d;
         hl_q         <= hl_d;
         hh_q         <= hh_d;
         orow_q       <= orow_d;
         ocol_q       <= ocol_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_ll     = ll_q;
   assign out_lh     = lh_q;
   assign out_hl     = hl_q;
   assign out_hh     = hh_q;
   assign out_row    = orow_q;
   assign out_col    = ocol_q;
   assign frame_done = frame_done_q;

endmodule
